rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one downstream resource, such as a display or bus port, between 8 requesters.
- Each requester raises one bit of iReq. The block grants exactly one requester at a time and holds that grant until the owner releases it.
- The grant is reported both as a one-hot vector and as a 3-bit binary index, using the same 8→3 encoding as the team's encoder83 datapath.

Parameters:
- N, 8, number of requesters (block is verified at 8 only).
- IDXW, 3, index width; IDXW = log2(N).
- MAX_HOLD, 16, cycle limit on one grant; used only when the optional feature is compiled in.

Ports:
- CLK  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- iReq  in  N  request vector; bit k = requester k wants the resource.
- iDone  in  1  current owner releases the resource; sampled only in GRANT.
- oGrant  out  N  one-hot grant; all zeros when idle.
- oIdx  out  IDXW  binary index of granted requester; 0 when idle.
- oValid  out  1  a grant is active.

Behaviour:
- Reset (synchronous, active-high, on CLK rising edge):
  - oGrant=0, oIdx=0, oValid=0.
  - Round-robin pointer ptr=0; state=IDLE.
- State IDLE:
  - If iReq != 0, pick the first set bit searching upward from ptr, wrapping 7→0.
  - On the next edge: oGrant=one-hot(pick), oIdx=pick, oValid=1, state→GRANT.
  - If iReq == 0, stay in IDLE; outputs stay 0.
- State GRANT:
  - Outputs hold stable.
  - Release condition: iDone=1, or iReq[oIdx]=0 (requester withdrew).
  - On release, next edge: ptr=(oIdx+1) mod 8 (wrap 7→0), outputs cleared, state→IDLE.
  - Changes to other iReq bits have no effect while in GRANT.
- Latency:
  - Request sampled at edge t, grant visible after edge t+1.
  - After every release there is one mandatory idle cycle with oValid=0 before the next grant, so back-to-back owners never overlap.
- Simultaneous events:
  - Release and new requests in the same cycle: release takes effect first, arbitration happens in the following IDLE cycle.
  - Multiple requests in IDLE: ptr decides the winner; bits below ptr have lowest priority.
- Reset mid-grant: grant drops on that edge and ptr returns to 0.
- Invariants:
  - oGrant is always zero or one-hot, and is consistent with oIdx and oValid.
  - A requester with continuous iReq is granted within 8 arbitration rounds (starvation-free).

Optional Feature:
- Macro: RR_ARB_HOLD_TIMEOUT_EN.
- When defined:
  - A hold counter is cleared on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1, the grant is force-released exactly like iDone.
  - Extra output port oTimeout (1 bit) pulses high for one cycle, coincident with the cycle where oValid falls because of the timeout.
- When undefined: no counter and no oTimeout port; a grant lasts indefinitely until iDone or withdrawal.

Decomposition:
- Package rr_arb_pkg:
  - constants N=8, IDXW=3;
  - state enum {IDLE, GRANT};
  - function rot_right/rot_left used for pointer-relative search.
- Sub-module rr_prio_enc8, purely combinational:
  - inputs: 8-bit request, 3-bit ptr;
  - outputs: 3-bit pick index and an any-request flag;
  - behaviour: rotate the request vector by ptr, fixed-priority encode from the lowest bit, then add ptr mod 8.
- Top rr_arbiter8 contains the FSM, the ptr register and the output registers.

Test Plan:
- Reset then iReq=8'b0000_0000 for 5 cycles → oValid=0, oGrant=0, oIdx=0 throughout.
- From reset (ptr=0), iReq=8'b1001_0100 held, iDone pulsed 3 cycles after each grant → successive oIdx 2, 4, 7, 2, with exactly one oValid=0 cycle between grants.
- iReq=8'b1000_0001 with ptr=7 reached via a prior grant of 6 → next grant idx 7, then wrap to idx 0.
- In GRANT idx=3, drop iReq[3] while iReq[5]=1 → release next edge, one idle cycle, then grant idx 5.
- Assert reset while oValid=1 at idx 4 → after that edge oValid=0, oGrant=0; next grant with iReq=8'hFF is idx 0.
- With RR_ARB_HOLD_TIMEOUT_EN and MAX_HOLD=16, hold iReq[1]=1 with no iDone → oValid high for exactly 16 cycles, oTimeout pulses once, the pointer advances, and the requester is re-granted after one idle cycle if it is the only requester.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and rotate helpers for the 8-way round-robin arbiter.
package rr_arb_pkg;

    localparam int N    = 8;
    localparam int IDXW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Bit 0 of the result is v[s]: makes the search start at the pointer.
    function automatic logic [N-1:0] rot_right(input logic [N-1:0] v, input logic [IDXW-1:0] s);
        logic [2*N-1:0] d;
        d = {v, v} >> s;
        return d[N-1:0];
    endfunction

    function automatic logic [N-1:0] rot_left(input logic [N-1:0] v, input logic [IDXW-1:0] s);
        logic [2*N-1:0] d;
        d = {v, v} << s;
        return d[2*N-1:N];
    endfunction

endpackage

// File: rtl/rr_prio_enc8.sv
// Pointer-relative priority encoder: first set request at or above ptr, wrapping 7->0.
module rr_prio_enc8
    import rr_arb_pkg::*;
(
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] pick,
    output logic            any_req
);

    logic [N-1:0]    rot;
    logic [N-1:0]    first_hot;
    logic [IDXW-1:0] offset;

    assign rot = rot_right(req, ptr);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_first
            if (gi == 0) begin : g_lsb
                assign first_hot[gi] = rot[0];
            end else begin : g_upper
                assign first_hot[gi] = rot[gi] & ~(|rot[gi-1:0]);
            end
        end
    endgenerate

    // first_hot is at most one-hot, so OR-ing the indices is an exact encode.
    always_comb begin
        offset = '0;
        for (int i = 0; i < N; i++) begin
            if (first_hot[i]) begin
                offset = offset | IDXW'(i);
            end
        end
    end

    assign pick    = offset + ptr;
    assign any_req = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with hold-until-release grants.
// Optional per-grant hold limit and oTimeout port: define RR_ARB_HOLD_TIMEOUT_EN.
module rr_arbiter8
    import rr_arb_pkg::*;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
#(
    parameter int MAX_HOLD = 16
)
`endif
(
    input  logic            CLK,
    input  logic            reset,
    input  logic [N-1:0]    iReq,
    input  logic            iDone,
    output logic [N-1:0]    oGrant,
    output logic [IDXW-1:0] oIdx,
    output logic            oValid
`ifdef RR_ARB_HOLD_TIMEOUT_EN
    ,
    output logic            oTimeout
`endif
);

    state_t          state_reg, state_next;
    logic [IDXW-1:0] ptr_reg, ptr_next;
    logic [IDXW-1:0] idx_reg, idx_next;
    logic [IDXW-1:0] pick;
    logic            any_req;
    logic            release_now;
    logic            timeout_hit;

    rr_prio_enc8 u_prio_enc (
        .req     (iReq),
        .ptr     (ptr_reg),
        .pick    (pick),
        .any_req (any_req)
    );

`ifdef RR_ARB_HOLD_TIMEOUT_EN
    localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HCW-1:0] hold_cnt_reg, hold_cnt_next;
    logic           timeout_reg, timeout_next;

    assign timeout_hit = (state_reg == GRANT) && (hold_cnt_reg == HCW'(MAX_HOLD - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Only meaningful while in GRANT; idx_reg holds the current owner there.
    assign release_now = iDone || !iReq[idx_reg] || timeout_hit;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            idx_reg      <= '0;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            idx_reg      <= idx_next;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
            hold_cnt_reg <= hold_cnt_next;
            timeout_reg  <= timeout_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next = GRANT;
                    idx_next   = pick;
                end
            end
            GRANT: begin
                // Release always lands in IDLE first, giving the mandatory gap cycle.
                if (release_now) begin
                    state_next = IDLE;
                    ptr_next   = idx_reg + IDXW'(1);
                    idx_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        hold_cnt_next = ((state_reg == GRANT) && !release_now) ? hold_cnt_reg + HCW'(1) : '0;
        timeout_next  = timeout_hit;
`endif
    end

    always_comb begin
        oValid = (state_reg == GRANT);
        oIdx   = oValid ? idx_reg : '0;
        oGrant = oValid ? rot_left({{(N-1){1'b0}}, 1'b1}, idx_reg) : '0;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        oTimeout = timeout_reg;
`endif
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus random traffic against an owner/pointer model.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 16;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       reset;
    logic [7:0] iReq;
    logic       iDone;
    logic [7:0] oGrant;
    logic [2:0] oIdx;
    logic       oValid;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
    logic       oTimeout;
`endif

    always #5 CLK = ~CLK;

`ifdef RR_ARB_HOLD_TIMEOUT_EN
    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .CLK(CLK), .reset(reset), .iReq(iReq), .iDone(iDone),
        .oGrant(oGrant), .oIdx(oIdx), .oValid(oValid), .oTimeout(oTimeout)
    );
`else
    rr_arbiter8 dut (
        .CLK(CLK), .reset(reset), .iReq(iReq), .iDone(iDone),
        .oGrant(oGrant), .oIdx(oIdx), .oValid(oValid)
    );
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: who owns the resource, where the search starts, how long held.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_timeout = 1'b0;

    // Observed transaction log
    int grants_q[$];
    int gaps_q[$];
    int runs_q[$];
    bit prev_valid;
    bit seen_grant;
    int idle_run;
    int high_run;
    int timeouts_seen;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [7:0] req, input logic done, input logic rst);
        bit found;
        bit to;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_timeout = 1'b0;
            return;
        end
        m_timeout = 1'b0;
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (!found && req[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_held  = 1;
                    found   = 1'b1;
                end
            end
        end else begin
            to = TO_EN && (m_held == MAX_HOLD);
            if (done || !req[m_owner] || to) begin
                m_ptr     = (m_owner + 1) % 8;
                m_owner   = -1;
                m_held    = 0;
                m_timeout = to;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic clear_log();
        grants_q.delete(); gaps_q.delete(); runs_q.delete();
        prev_valid = oValid; seen_grant = 1'b0;
        idle_run = 0; high_run = 0; timeouts_seen = 0;
    endtask

    task automatic step(input logic [7:0] req, input logic done, input logic rst);
        bit exp_valid;
        iReq = req; iDone = done; reset = rst;
        model_edge(req, done, rst);
        @(posedge CLK);
        #1;
        exp_valid = (m_owner >= 0);
        check_eq("valid", oValid, exp_valid);
        check_eq("idx", oIdx, exp_valid ? m_owner : 0);
        check_eq("grant", oGrant, exp_valid ? (32'd1 << m_owner) : 32'd0);
        check_eq("onehot", 32'($countones(oGrant) <= 1), 32'd1);
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        check_eq("timeout", oTimeout, m_timeout);
        if (oTimeout) timeouts_seen++;
`endif
        if (oValid && !prev_valid) begin
            grants_q.push_back(int'(oIdx));
            if (seen_grant) gaps_q.push_back(idle_run);
            seen_grant = 1'b1;
            idle_run = 0;
            high_run = 0;
            $display("[TB] grant idx=%0d at %0t", oIdx, $time);
        end
        if (!oValid && prev_valid) runs_q.push_back(high_run);
        if (oValid) high_run++; else idle_run++;
        prev_valid = oValid;
    endtask

    task automatic expect_grants(input string tag, input int n,
                                 input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        check_eq({tag, "_count"}, 32'(grants_q.size() >= n), 32'd1);
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_seq"}, (i < grants_q.size()) ? grants_q[i] : -1, e[i]);
            if (i > 0)
                check_eq({tag, "_gap"}, (i - 1 < gaps_q.size()) ? gaps_q[i-1] : -1, 1);
        end
    endtask

    task automatic do_reset();
        step(8'h00, 1'b0, 1'b1);
        clear_log();
    endtask

    initial begin
        logic [7:0] rreq;
        logic       rdone;
        iReq = 8'h00; iDone = 1'b0; reset = 1'b1;

        // Idle after reset
        do_reset();
        for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b0);
        check_eq("idle_nogrant", grants_q.size(), 0);

        // Rotation through 2,4,7,2 with iDone three cycles into each grant
        do_reset();
        for (int i = 0; i < 20; i++) step(8'b1001_0100, (m_owner >= 0) && (m_held == 3), 1'b0);
        expect_grants("rot", 4, 2, 4, 7, 2);

        // ptr=7 via grant of 6, then 7 then wrap to 0
        do_reset();
        step(8'h40, 1'b0, 1'b0);
        step(8'h40, 1'b1, 1'b0);
        step(8'h81, 1'b0, 1'b0);
        step(8'h81, 1'b1, 1'b0);
        step(8'h81, 1'b0, 1'b0);
        step(8'h81, 1'b0, 1'b0);
        expect_grants("wrap", 3, 6, 7, 0, 0);

        // Withdrawal of owner 3 while 5 waits
        do_reset();
        step(8'h08, 1'b0, 1'b0);
        step(8'h08, 1'b0, 1'b0);
        step(8'h20, 1'b0, 1'b0);
        step(8'h20, 1'b0, 1'b0);
        step(8'h20, 1'b0, 1'b0);
        expect_grants("withdraw", 2, 3, 5, 0, 0);

        // Reset while owner 4 holds the grant
        do_reset();
        step(8'h10, 1'b0, 1'b0);
        step(8'h10, 1'b0, 1'b0);
        step(8'h10, 1'b0, 1'b1);
        check_eq("midrst_valid", oValid, 0);
        check_eq("midrst_grant", oGrant, 0);
        clear_log();
        step(8'hFF, 1'b0, 1'b0);
        step(8'hFF, 1'b0, 1'b0);
        expect_grants("midrst", 1, 0, 0, 0, 0);

`ifdef RR_ARB_HOLD_TIMEOUT_EN
        // Hold limit: sole requester 1, never releases
        do_reset();
        for (int i = 0; i < 19; i++) step(8'h02, 1'b0, 1'b0);
        check_eq("to_run", (runs_q.size() > 0) ? runs_q[0] : -1, MAX_HOLD);
        check_eq("to_pulses", timeouts_seen, 1);
        expect_grants("to", 2, 1, 1, 0, 0);
`endif

        // Random traffic against the model
        do_reset();
        rreq = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rreq = 8'($urandom);
            rdone = ($urandom_range(0, 4) == 0);
            step(rreq, rdone, $urandom_range(0, 99) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
